// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit seven-segment scanner with PWM brightness, dead time and
// frame-synchronous input latching. Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned REFRESH_HZ  = 1000,
  parameter int unsigned BRIGHT_BITS = 4,
  parameter int unsigned SIMULATE    = 0
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [5*NUM_DIGITS-1:0]                                digits,
  input  logic [NUM_DIGITS-1:0]                                  dp_in,
  input  logic [NUM_DIGITS-1:0]                                  dig_en,
  input  logic [BRIGHT_BITS-1:0]                                 brightness,
  output logic [6:0]                                             seg,
  output logic                                                   dp,
  output logic [NUM_DIGITS-1:0]                                  an,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                                   frame_tick
);

  localparam int unsigned IdxW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned TickDiv = CLK_FREQ_HZ / (REFRESH_HZ * (2 ** BRIGHT_BITS));
  localparam int unsigned Tick    = (SIMULATE != 0) ? 4 : ((TickDiv > 0) ? TickDiv : 1);
  localparam int unsigned PreW    = (Tick > 1) ? $clog2(Tick) : 1;

  logic [PreW-1:0]         pre_q, pre_d;
  logic [BRIGHT_BITS-1:0]  sub_q, sub_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    frame_q, frame_d;
  logic [5*NUM_DIGITS-1:0] sh_code_q, sh_code_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [NUM_DIGITS-1:0]   blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic       strobe;
  logic [4:0] sel_code;
  logic       sel_en, sel_dp, sel_blank;

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'h40;
      5'd1:    s = 7'h79;
      5'd2:    s = 7'h24;
      5'd3:    s = 7'h30;
      5'd4:    s = 7'h19;
      5'd5:    s = 7'h12;
      5'd6:    s = 7'h02;
      5'd7:    s = 7'h78;
      5'd8:    s = 7'h00;
      5'd9:    s = 7'h10;
      5'd10:   s = 7'h08;
      5'd11:   s = 7'h03;
      5'd12:   s = 7'h46;
      5'd13:   s = 7'h21;
      5'd14:   s = 7'h06;
      5'd15:   s = 7'h0E;
      5'd16:   s = 7'h3F;
      5'd17:   s = 7'h77;
      5'd18:   s = 7'h1C;
      5'd19:   s = 7'h23;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign strobe = (pre_q == PreW'(Tick - 1));

  // Counters; shadows only reload on the frame wrap so a frame never tears.
  always_comb begin
    pre_d     = pre_q + PreW'(1);
    sub_d     = sub_q;
    idx_d     = idx_q;
    frame_d   = 1'b0;
    sh_code_d = sh_code_q;
    sh_dp_d   = sh_dp_q;
    sh_en_d   = sh_en_q;
    if (strobe) begin
      pre_d = '0;
      sub_d = sub_q + BRIGHT_BITS'(1);
      if (sub_q == '1) begin
        if (idx_q == IdxW'(NUM_DIGITS - 1)) begin
          idx_d     = '0;
          frame_d   = 1'b1;
          sh_code_d = digits;
          sh_dp_d   = dp_in;
          sh_en_d   = dig_en;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
    end
  end

`ifdef SEG7_LZB_EN
  logic [NUM_DIGITS-1:0] blank_q;

  // Zeros above the highest enabled non-zero digit go dark; digit 0 always shows.
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [5*NUM_DIGITS-1:0] codes,
                                                     input logic [NUM_DIGITS-1:0]   en);
    logic [NUM_DIGITS-1:0] mask;
    logic                  found;
    mask  = '0;
    found = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (en[i] && (codes[5*i +: 5] != 5'd0)) found = 1'b1;
      mask[i] = !found && (codes[5*i +: 5] == 5'd0);
    end
    return mask;
  endfunction

  always_comb begin
    blank_d = blank_q;
    if (frame_d) blank_d = lzb_mask(digits, dig_en);
  end

  always_ff @(posedge clk) begin
    if (reset) blank_q <= '0;
    else       blank_q <= blank_d;
  end
`else
  assign blank_d = '0;
`endif

  always_comb begin
    sel_code  = '0;
    sel_en    = 1'b0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_d == IdxW'(i)) begin
        sel_code  = sh_code_d[5*i +: 5];
        sel_en    = sh_en_d[i];
        sel_dp    = sh_dp_d[i];
        sel_blank = blank_d[i];
      end
    end
  end

  // Sub-slot 0 is dead time so the previous digit's anode fully releases.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    dp_d  = dp_q;
    if (strobe) begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if ((sub_d != '0) && sel_en && (sub_d <= brightness)) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (idx_d == IdxW'(i)) an_d[i] = 1'b0;
        end
        seg_d = sel_blank ? 7'h7F : decode(sel_code);
        dp_d  = ~sel_dp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q     <= '0;
      sub_q     <= '0;
      idx_q     <= '0;
      frame_q   <= 1'b0;
      sh_code_q <= '0;
      sh_dp_q   <= '0;
      sh_en_q   <= '0;
      an_q      <= '1;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      pre_q     <= pre_d;
      sub_q     <= sub_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      sh_code_q <= sh_code_d;
      sh_dp_q   <= sh_dp_d;
      sh_en_q   <= sh_en_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_idx  = idx_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized bench for seg7_scan_mux (4 digits, 2 brightness bits, 4-clock tick) against a
// reference model derived from the clock count since reset.
module tb_seg7_scan_mux;

  localparam int ND    = 4;
  localparam int BB    = 2;
  localparam int TICK  = 4;
  localparam int SUBS  = 4;
  localparam int SLOT  = TICK * SUBS;
  localparam int FRAME = ND * SLOT;

  logic            clk = 1'b0;
  logic            reset;
  logic [5*ND-1:0] digits;
  logic [ND-1:0]   dp_in;
  logic [ND-1:0]   dig_en;
  logic [BB-1:0]   brightness;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   an;
  logic [1:0]      digit_idx;
  logic            frame_tick;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_mux #(
    .NUM_DIGITS (ND),
    .CLK_FREQ_HZ(100000000),
    .REFRESH_HZ (1000),
    .BRIGHT_BITS(BB),
    .SIMULATE   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits    (digits),
    .dp_in     (dp_in),
    .dig_en    (dig_en),
    .brightness(brightness),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  // Reference model: e = clock edges since reset released.
  int            e;
  int            hi;
  logic [4:0]    sh_code [ND];
  logic [ND-1:0] sh_dp, sh_en, sh_blank;
  int            m_bright;

  function automatic logic [6:0] seg_of(input logic [4:0] code);
    case (code)
      5'd0: return 7'h40;   5'd1: return 7'h79;   5'd2: return 7'h24;   5'd3: return 7'h30;
      5'd4: return 7'h19;   5'd5: return 7'h12;   5'd6: return 7'h02;   5'd7: return 7'h78;
      5'd8: return 7'h00;   5'd9: return 7'h10;   5'd10: return 7'h08;  5'd11: return 7'h03;
      5'd12: return 7'h46;  5'd13: return 7'h21;  5'd14: return 7'h06;  5'd15: return 7'h0E;
      5'd16: return 7'h3F;  5'd17: return 7'h77;  5'd18: return 7'h1C;  5'd19: return 7'h23;
      default: return 7'h7F;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      e = 0;
      sh_dp = '0;
      sh_en = '0;
      sh_blank = '0;
      for (int i = 0; i < ND; i++) sh_code[i] = 5'd0;
      m_bright = 0;
    end else begin
      e++;
      if (e % TICK == 0) begin
        m_bright = int'(brightness);
        if (e % FRAME == 0) begin
          hi = -1;
          for (int i = 0; i < ND; i++) begin
            sh_code[i] = digits[5*i +: 5];
            if (dig_en[i] && sh_code[i] != 5'd0) hi = i;
          end
          sh_dp = dp_in;
          sh_en = dig_en;
          sh_blank = '0;
`ifdef SEG7_LZB_EN
          for (int i = 1; i < ND; i++) if (i > hi && sh_code[i] == 5'd0) sh_blank[i] = 1'b1;
`endif
        end
      end
    end
  end

  int            m_slot, m_sub, m_idx;
  logic [ND-1:0] exp_an;
  logic [6:0]    exp_seg;
  logic          exp_dp, exp_ft;
  logic [1:0]    exp_idx;

  always_comb begin
    m_slot  = e / TICK;
    m_sub   = m_slot % SUBS;
    m_idx   = (m_slot / SUBS) % ND;
    exp_an  = '1;
    exp_seg = 7'h7F;
    exp_dp  = 1'b1;
    exp_idx = 2'(m_idx);
    exp_ft  = (e != 0) && (e % FRAME == 0);
    if (m_sub != 0 && sh_en[m_idx] && m_sub <= m_bright) begin
      exp_an[m_idx] = 1'b0;
      exp_seg = sh_blank[m_idx] ? 7'h7F : seg_of(sh_code[m_idx]);
      exp_dp  = ~sh_dp[m_idx];
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int lit;
    digits = 20'($urandom);
    dp_in = '1;
    dig_en = '1;
    brightness = 2'd3;
    apply_reset();
    vectors += 5;
    if (an !== 4'hF) begin miscompares++; $display("FAIL reset_an got %h want f", an); end
    if (seg !== 7'h7F) begin miscompares++; $display("FAIL reset_seg got %h want 7f", seg); end
    if (dp !== 1'b1) begin miscompares++; $display("FAIL reset_dp got %b want 1", dp); end
    if (digit_idx !== 2'd0) begin
      miscompares++; $display("FAIL reset_idx got %0d want 0", digit_idx);
    end
    if (frame_tick !== 1'b0) begin
      miscompares++; $display("FAIL reset_ft got %b want 0", frame_tick);
    end
    lit = 0;
    for (int c = 0; c < FRAME - 1; c++) begin
      @(negedge clk);
      if (an !== 4'hF) lit++;
    end
    vectors++;
    if (lit != 0) begin miscompares++; $display("FAIL reset_dark_frame got %0d lit want 0", lit); end
  endtask

  task automatic test_timing();
    int low [ND];
    int dark, prev_ft, last_ft;
    digits = 20'($urandom);
    dp_in = 4'($urandom);
    dig_en = '1;
    brightness = 2'd3;
    apply_reset();
    for (int i = 0; i < ND; i++) low[i] = 0;
    dark = 0; prev_ft = -1; last_ft = -1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_ft}) begin
        miscompares++;
        $display("FAIL timing e=%0d got an=%h seg=%h dp=%b idx=%0d ft=%b want an=%h seg=%h dp=%b idx=%0d ft=%b",
                 e, an, seg, dp, digit_idx, frame_tick, exp_an, exp_seg, exp_dp, exp_idx, exp_ft);
      end
      if (frame_tick === 1'b1) begin prev_ft = last_ft; last_ft = c; end
      if (e >= FRAME && e < 2 * FRAME) begin
        for (int i = 0; i < ND; i++) if (an[i] === 1'b0) low[i]++;
        if (an === 4'hF) dark++;
      end
    end
    vectors++;
    if (last_ft - prev_ft != FRAME || prev_ft < 0) begin
      miscompares++; $display("FAIL frame_period got %0d want %0d", last_ft - prev_ft, FRAME);
    end
    for (int i = 0; i < ND; i++) begin
      vectors++;
      if (low[i] != 3 * TICK) begin
        miscompares++; $display("FAIL an_low_%0d got %0d want %0d", i, low[i], 3 * TICK);
      end
    end
    vectors++;
    if (dark != ND * TICK) begin
      miscompares++; $display("FAIL dead_time got %0d want %0d", dark, ND * TICK);
    end
  endtask

  task automatic test_decode();
    logic [6:0] seen [ND];
    logic [ND-1:0] dp_seen;
    logic [6:0] want [ND];
    int lit;
    want[0] = 7'h40; want[1] = 7'h79; want[2] = 7'h00; want[3] = 7'h0E;
    digits = {5'd15, 5'd8, 5'd1, 5'd0};
    dp_in = 4'b0100;
    dig_en = '1;
    brightness = 2'd3;
    apply_reset();
    for (int i = 0; i < ND; i++) seen[i] = 7'h55;
    dp_seen = 'x;
    lit = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (e < FRAME && an !== 4'hF) lit++;
      if (e >= FRAME) begin
        for (int i = 0; i < ND; i++) if (an[i] === 1'b0) begin seen[i] = seg; dp_seen[i] = dp; end
      end
    end
    vectors++;
    if (lit != 0) begin miscompares++; $display("FAIL decode_first_dark got %0d lit want 0", lit); end
    for (int i = 0; i < ND; i++) begin
      vectors++;
      if (seen[i] !== want[i]) begin
        miscompares++; $display("FAIL decode_slot%0d got %h want %h", i, seen[i], want[i]);
      end
    end
    vectors++;
    if (dp_seen !== 4'b1011) begin
      miscompares++; $display("FAIL decode_dp got %b want 1011", dp_seen);
    end
  endtask

  task automatic test_midframe();
    brightness = 2'd3;
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_ft}) begin
        miscompares++;
        $display("FAIL midframe e=%0d got an=%h seg=%h dp=%b idx=%0d ft=%b want an=%h seg=%h dp=%b idx=%0d ft=%b",
                 e, an, seg, dp, digit_idx, frame_tick, exp_an, exp_seg, exp_dp, exp_idx, exp_ft);
      end
      if ($urandom_range(0, 7) == 0) begin
        digits = 20'($urandom);
        dp_in = 4'($urandom);
        dig_en = 4'($urandom);
      end
    end
  endtask

  task automatic test_enable_brightness();
    int low [ND];
    int waited;
    dig_en = 4'b1010;
    brightness = 2'd0;
    digits = 20'($urandom);
    dp_in = 4'($urandom);
    waited = 0;
    do begin @(negedge clk); waited++; end while (frame_tick !== 1'b1 && waited < 3 * FRAME);
    vectors++;
    if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL en_wait_ft got %b want 1", frame_tick); end
    for (int b = 0; b < 2; b++) begin
      brightness = 2'(b);
      for (int i = 0; i < ND; i++) low[i] = 0;
      for (int c = 0; c < FRAME; c++) begin
        if (c > 0) @(negedge clk);
        vectors++;
        if ({an, seg, dp, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_ft}) begin
          miscompares++;
          $display("FAIL enable e=%0d got an=%h seg=%h dp=%b idx=%0d ft=%b want an=%h seg=%h dp=%b idx=%0d ft=%b",
                   e, an, seg, dp, digit_idx, frame_tick, exp_an, exp_seg, exp_dp, exp_idx, exp_ft);
        end
        for (int i = 0; i < ND; i++) if (an[i] === 1'b0) low[i]++;
      end
      for (int i = 0; i < ND; i++) begin
        vectors++;
        if (low[i] != (dig_en[i] ? b * TICK : 0)) begin
          miscompares++;
          $display("FAIL en_b%0d_an%0d got %0d want %0d", b, i, low[i], dig_en[i] ? b * TICK : 0);
        end
      end
      @(negedge clk);
      vectors++;
      if (frame_tick !== 1'b1) begin
        miscompares++; $display("FAIL en_period_b%0d got ft=%b want 1", b, frame_tick);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int waited, lit;
    dig_en = '1;
    brightness = 2'd3;
    digits = 20'($urandom);
    waited = 0;
    do begin @(negedge clk); waited++; end while (digit_idx !== 2'd2 && waited < 2 * FRAME);
    vectors++;
    if (digit_idx !== 2'd2) begin miscompares++; $display("FAIL rst_wait_idx got %0d want 2", digit_idx); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vectors += 4;
    if (an !== 4'hF) begin miscompares++; $display("FAIL rst_mid_an got %h want f", an); end
    if (seg !== 7'h7F) begin miscompares++; $display("FAIL rst_mid_seg got %h want 7f", seg); end
    if (digit_idx !== 2'd0) begin
      miscompares++; $display("FAIL rst_mid_idx got %0d want 0", digit_idx);
    end
    if (frame_tick !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_ft got %b want 0", frame_tick);
    end
    lit = 0;
    for (int c = 0; c < FRAME + SLOT; c++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_ft}) begin
        miscompares++;
        $display("FAIL rst_mid e=%0d got an=%h seg=%h dp=%b idx=%0d ft=%b want an=%h seg=%h dp=%b idx=%0d ft=%b",
                 e, an, seg, dp, digit_idx, frame_tick, exp_an, exp_seg, exp_dp, exp_idx, exp_ft);
      end
      if (e < FRAME && an !== 4'hF) lit++;
    end
    vectors++;
    if (lit != 0) begin miscompares++; $display("FAIL rst_mid_dark got %0d lit want 0", lit); end
  endtask

  task automatic test_lzb();
    logic [6:0] seen [ND];
    logic [6:0] want [2][ND];
    logic [ND-1:0] dp_seen;
    int waited;
`ifdef SEG7_LZB_EN
    want[0] = '{7'h40, 7'h79, 7'h7F, 7'h7F};
    want[1] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
    want[0] = '{7'h40, 7'h79, 7'h40, 7'h40};
    want[1] = '{7'h40, 7'h40, 7'h40, 7'h40};
`endif
    dig_en = '1;
    dp_in = '1;
    brightness = 2'd3;
    for (int t = 0; t < 2; t++) begin
      digits = (t == 0) ? {5'd0, 5'd0, 5'd1, 5'd0} : 20'd0;
      waited = 0;
      do begin @(negedge clk); waited++; end while (frame_tick !== 1'b1 && waited < 3 * FRAME);
      vectors++;
      if (frame_tick !== 1'b1) begin miscompares++; $display("FAIL lzb_wait_ft got %b want 1", frame_tick); end
      for (int i = 0; i < ND; i++) seen[i] = 7'h55;
      dp_seen = '1;
      for (int c = 0; c < FRAME - 1; c++) begin
        @(negedge clk);
        for (int i = 0; i < ND; i++) if (an[i] === 1'b0) begin seen[i] = seg; dp_seen[i] = dp; end
      end
      for (int i = 0; i < ND; i++) begin
        vectors++;
        if (seen[i] !== want[t][i]) begin
          miscompares++; $display("FAIL lzb_case%0d_dig%0d got %h want %h", t, i, seen[i], want[t][i]);
        end
      end
      vectors++;
      if (dp_seen !== 4'b0000) begin
        miscompares++; $display("FAIL lzb_case%0d_dp got %b want 0000", t, dp_seen);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 6 * FRAME; c++) begin
      @(negedge clk);
      vectors++;
      if ({an, seg, dp, digit_idx, frame_tick} !== {exp_an, exp_seg, exp_dp, exp_idx, exp_ft}) begin
        miscompares++;
        $display("FAIL random e=%0d got an=%h seg=%h dp=%b idx=%0d ft=%b want an=%h seg=%h dp=%b idx=%0d ft=%b",
                 e, an, seg, dp, digit_idx, frame_tick, exp_an, exp_seg, exp_dp, exp_idx, exp_ft);
      end
      if ($urandom_range(0, 9) == 0) begin
        digits = 20'($urandom);
        dp_in = 4'($urandom);
        dig_en = 4'($urandom);
      end
      if ($urandom_range(0, 19) == 0) brightness = 2'($urandom);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    digits = '0;
    dp_in = '0;
    dig_en = '0;
    brightness = '0;
    test_reset();
    test_timing();
    test_decode();
    test_midframe();
    test_enable_brightness();
    test_reset_midframe();
    test_lzb();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
